// File: rtl/uart_tx_engine.sv
// UART transmitter: pops bytes from the transmit FIFO and shifts them out as start/data/stop frames.
// Defining UART_TX_PARITY_EN adds one even-parity bit between the data bits and the stop bit.
module uart_tx_engine #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_engine: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } state_e;

  state_e           state_r, state_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_next_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             tx_r, tx_s;
  logic             rd_en_r, rd_en_s;
  logic             busy_r, busy_s;
  logic             start_s;
  logic             bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic             par_r, par_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] data);
    even_parity = ^data;
  endfunction
`endif

  // Next-state, datapath update and decode of the next-cycle line outputs
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
`ifdef UART_TX_PARITY_EN
    par_s      = par_r;
`endif
    start_s    = tx_en_i && !fifo_empty_i;
    bit_end_s  = (cnt_r == CNT_LAST);
    cnt_next_s = bit_end_s ? CNT_ZERO : (cnt_r + CNT_ONE);

    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_POP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_POP: state_s = ST_LOAD;
      ST_LOAD: begin
        shift_s = fifo_data_i;
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
`ifdef UART_TX_PARITY_EN
        par_s   = even_parity(fifo_data_i);
`endif
        state_s = ST_START;
      end
      ST_START: begin
        cnt_s = cnt_next_s;
        if (bit_end_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        cnt_s = cnt_next_s;
        if (bit_end_s) begin
          shift_s = shift_r >> 1'b1;
          if (idx_r == IDX_LAST) begin
            idx_s = IDX_ZERO;
`ifdef UART_TX_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
          end else begin
            idx_s   = idx_r + IDX_ONE;
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        cnt_s = cnt_next_s;
        if (bit_end_s) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        cnt_s = cnt_next_s;
        if (bit_end_s && start_s) begin
          state_s = ST_POP;
        end else if (bit_end_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        shift_s = {WIDTH{1'b0}};
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
      end
    endcase

    // Outputs are registered from the upcoming state so they line up with it
    case (state_s)
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_s = par_s;
`endif
      default:   tx_s = 1'b1;
    endcase
    rd_en_s = (state_s == ST_POP);
    busy_s  = (state_s != ST_IDLE);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
      tx_r    <= 1'b1;
      rd_en_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
      tx_r    <= tx_s;
      rd_en_r <= rd_en_s;
      busy_r  <= busy_s;
    end
  end

  assign tx_o         = tx_r;
  assign fifo_rd_en_o = rd_en_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: a FIFO model feeds bytes, a line monitor rebuilds each frame
// and compares it with a waveform computed from the frame rules.
module tb_uart_tx_engine;

  localparam int DIV   = 16 / 4;
  localparam int WIDTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_LEN = (WIDTH + 2 + PAR_BITS) * DIV;

  logic       clk;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = 8'h00;
  logic       tx;
  logic       busy;

  logic       push_v = 1'b0;
  logic [7:0] push_d = 8'h00;
  logic       fifo_clr = 1'b0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  int total = 0;
  int bad = 0;
  int pops = 0;
  int last_gap = 0;
  bit cap_active = 1'b0;

  uart_tx_engine #(.CLK_FREQ(16), .BAUD_RATE(4), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_en_i      (tx_en),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_data_i  (fifo_data),
    .tx_o         (tx),
    .busy_o       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level k cycles after the start-bit edge, from the frame rules
  function automatic logic ref_line(input logic [7:0] d, input int k);
    int slot = k / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= WIDTH) return d[slot-1];
    if (PAR_BITS == 1 && slot == WIDTH + 1) return logic'($countones(d) % 2);
    return 1'b1;
  endfunction

  // FIFO model: registered read data one cycle after the pop
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_q.delete();
    end else begin
      if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      if (push_v) fifo_q.push_back(push_d);
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Line monitor and scoreboard
  initial begin
    logic [63:0] cap_bits, exp_bits;
    logic [7:0]  d;
    int cap_idx, high_run;
    logic rd_prev;
    cap_bits = 64'd0; cap_idx = 0; high_run = 0; rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        if (cap_active && exp_q.size() > 0) void'(exp_q.pop_front());
        cap_active = 1'b0;
        high_run = 0;
        rd_prev = 1'b0;
      end else begin
        check("rd_en_when_empty", fifo_rd_en & fifo_empty, 1'b0);
        check("rd_en_back_to_back", fifo_rd_en & rd_prev, 1'b0);
        rd_prev = fifo_rd_en;
        if (fifo_rd_en === 1'b1) pops++;
        if (cap_active) begin
          cap_bits[cap_idx] = tx;
          cap_idx++;
          if (cap_idx == FRAME_LEN) begin
            cap_active = 1'b0;
            high_run = 0;
            check("frame_has_expectation", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
              d = exp_q.pop_front();
              exp_bits = 64'd0;
              for (int k = 0; k < FRAME_LEN; k++) exp_bits[k] = ref_line(d, k);
              check("frame_waveform", cap_bits, exp_bits);
            end
          end
        end else if (tx === 1'b0) begin
          last_gap = high_run;
          cap_active = 1'b1;
          cap_bits = 64'd0;
          cap_idx = 1;
        end else begin
          high_run++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit expect_tx);
    tick();
    push_v = 1'b1;
    push_d = b;
    if (expect_tx) exp_q.push_back(b);
    tick();
    push_v = 1'b0;
  endtask

  task automatic clear_fifo();
    tick();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || fifo_empty !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < budget, 1'b1);
  endtask

  // Directed frame with start latency, pop pulse and busy fall checks
  task automatic single_frame(input logic [7:0] b);
    int p0 = pops;
    push(b, 1'b1);
    @(negedge clk);
    check("sf_idle_tx", tx, 1'b1);
    check("sf_idle_busy", busy, 1'b0);
    @(negedge clk);
    check("sf_pop", fifo_rd_en, 1'b1);
    check("sf_busy_rise", busy, 1'b1);
    @(negedge clk);
    check("sf_load_rd_en", fifo_rd_en, 1'b0);
    check("sf_load_tx", tx, 1'b1);
    @(negedge clk);
    check("sf_start_low", tx, 1'b0);
    repeat (FRAME_LEN - 1) @(negedge clk);
    check("sf_last_stop_busy", busy, 1'b1);
    @(negedge clk);
    check("sf_busy_fall", busy, 1'b0);
    check("sf_line_idle", tx, 1'b1);
    check("sf_one_pop", pops - p0, 1);
  endtask

  initial begin
    int p0, lows;
    // reset with a non-empty FIFO
    tick();
    tick();
    tx_en = 1'b1;
    push(8'h11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_rd_en", fifo_rd_en, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    clear_fifo();
    check("rst_no_pop", pops, 0);
    tick();
    rst_n = 1'b1;

    single_frame(8'hA5);
    single_frame(8'h07);
    single_frame(8'h03);

    // empty FIFO with transmit enabled
    p0 = pops;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("empty_line_high", lows, 0);
    check("empty_no_pop", pops - p0, 0);

    // back-to-back frames
    p0 = pops;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    wait_idle(4 * FRAME_LEN);
    check("b2b_gap", last_gap, 2);
    check("b2b_pops", pops - p0, 2);
    check("b2b_fifo_empty", fifo_empty, 1'b1);
    check("b2b_line_idle", tx, 1'b1);

    // disable mid-frame: first frame finishes, nothing more is popped
    p0 = pops;
    push(8'hC3, 1'b1);
    push(8'h81, 1'b0);
    push(8'h42, 1'b0);
    repeat (16) tick();
    tx_en = 1'b0;
    repeat (FRAME_LEN + 10) @(negedge clk);
    check("dis_pops", pops - p0, 1);
    check("dis_remaining", fifo_q.size(), 2);
    check("dis_busy", busy, 1'b0);
    check("dis_line_idle", tx, 1'b1);
    clear_fifo();
    tx_en = 1'b1;

    // reset during data bit 3 of 0x5A, then the queued byte goes out
    push(8'h5A, 1'b1);
    push(8'h3C, 1'b1);
    repeat (18) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_tx", tx, 1'b1);
    check("mrst_busy", busy, 1'b0);
    check("mrst_rd_en", fifo_rd_en, 1'b0);
    @(negedge clk);
    check("mrst_next_pop", fifo_rd_en, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("mrst_next_start", tx, 1'b0);
    wait_idle(4 * FRAME_LEN);

    // random traffic with random spacing
    for (int i = 0; i < 12; i++) begin
      push(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 60)) tick();
    end
    wait_idle(20 * FRAME_LEN);

    repeat (4) @(negedge clk);
    check("all_frames_seen", exp_q.size(), 0);
    check("no_partial_frame", cap_active, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmitter that drains bytes from the peripheral transmit FIFO and shifts them out on an 8N1 UART line. It sits directly downstream of the transmit-side FIFO in the UART peripheral. It pops one entry per frame through the FIFO's read handshake: `rd_en` while not empty, with the data registered by the FIFO one cycle later. It generates its own baud timing from the system clock.

## Interface
Parameters:
- `CLK_FREQ`, 25_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bit/s.
- `WIDTH`, 8: data bits per frame; must match the FIFO `WIDTH`.
- Derived: `BAUD_DIV = CLK_FREQ / BAUD_RATE` (integer division). Elaboration fails if `BAUD_DIV < 2`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `tx_en_i`  in  1  permission to start new frames.
- `fifo_empty_i`  in  1  FIFO empty flag.
- `fifo_rd_en_o`  out  1  FIFO pop strobe, one cycle per frame.
- `fifo_data_i`  in  WIDTH  FIFO registered read data; valid the cycle after the pop.
- `tx_o`  out  1  serial line, idle high; registered.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- **Frame format:** start bit (0), WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- **State machine:** IDLE, POP, LOAD, START, DATA, PARITY (only with the macro defined), STOP.
- **IDLE:**
  - `tx_o`=1.
  - If `tx_en_i` && !`fifo_empty_i`, go to POP.
- **POP:** exactly one cycle with `fifo_rd_en_o`=1; go to LOAD.
  - This block is the only FIFO consumer, so the FIFO is still non-empty here.
- **LOAD:**
  - Capture `fifo_data_i` into the shift register.
  - Clear the baud counter and bit index.
  - Go to START.
- **Bit timing:**
  - The baud counter runs 0..BAUD_DIV-1.
  - Every bit, START through STOP, lasts exactly BAUD_DIV cycles.
  - The state and shift advance on the cycle the counter equals BAUD_DIV-1.
- **DATA:**
  - `tx_o` = shift register bit 0.
  - The shift register shifts right at each bit end.
  - The bit index counts 0..WIDTH-1; after bit WIDTH-1, go to PARITY or STOP.
- **STOP:** `tx_o`=1. On the last cycle of the stop bit:
  - if `tx_en_i` && !`fifo_empty_i`, go to POP;
  - otherwise go to IDLE.
- **`tx_en_i` deasserted mid-frame:** the current frame completes unchanged. No further pop occurs.
- **FIFO empty:** no pop, and `fifo_rd_en_o` is never asserted while `fifo_empty_i`=1.
- **Reset, including mid-frame:**
  - State=IDLE; `tx_o`=1; `fifo_rd_en_o`=0; `busy_o`=0.
  - Shift register, counter and bit index = 0.
  - The partial frame is aborted. No FIFO entry is consumed by the aborted frame beyond the one already popped.

## Timing
- **Reset values:** `tx_o`=1, `fifo_rd_en_o`=0, `busy_o`=0.
- **Start of frame:** if IDLE samples the start condition in cycle t:
  - POP is cycle t+1;
  - LOAD is cycle t+2;
  - `tx_o` goes low starting cycle t+3.
- **Frame duration:** (WIDTH+2)·BAUD_DIV cycles without parity, (WIDTH+3)·BAUD_DIV with parity.
- **Back-to-back frames:** exactly 2 extra high cycles (POP, LOAD) between the end of one stop bit and the next start bit.
- **`busy_o`:** rises in cycle t+1 and falls on the first IDLE cycle.
- **`fifo_rd_en_o`:** never high for two consecutive cycles.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the PARITY state is compiled in;
  - after the data bits, one bit of even parity (XOR of all WIDTH data bits) is sent for BAUD_DIV cycles.
- Not defined:
  - no PARITY state, and DATA goes directly to STOP;
  - the frame is 8N1 for WIDTH=8.

## Test plan
All tests use CLK_FREQ=16 and BAUD_RATE=4, so BAUD_DIV=4, with a behavioural FIFO model attached.
- **Reset values:** hold `rst_n`=0 for 3 cycles with the FIFO non-empty -> `tx_o`=1, `fifo_rd_en_o`=0, `busy_o`=0 throughout.
- **Single byte:** push 0xA5, `tx_en_i`=1 -> exactly one `fifo_rd_en_o` pulse. `tx_o` then shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles), starting 3 cycles after empty drops. `busy_o` then falls.
- **Back-to-back:** push 0x00 and 0xFF -> two pops, two frames separated by exactly 2 high cycles after the first stop bit. FIFO empty at the end; line idle high.
- **Empty FIFO / disable:**
  - FIFO empty for 100 cycles -> no pop, `tx_o`=1.
  - Push 3 bytes, deassert `tx_en_i` mid-way through the first frame -> the first frame completes, no further pops, 2 entries remain.
- **Reset mid-frame:** pulse `rst_n` low during data bit 3 of 0x5A -> `tx_o`=1 on the following cycle, `busy_o`=0. After release, the next queued byte transmits with correct timing.
- **Parity (`UART_TX_PARITY_EN`):**
  - 0x07 -> parity bit 1, frame length 44 cycles.
  - 0x03 -> parity bit 0.
